// File: rtl/sort_pkg.sv
// Shared constants and FSM encoding for the serial sort datapath.
// No logic; imported by the collector and its interface users.
package sort_pkg;

  localparam int DEPTH = 10;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/sort_collector_if.sv
// Sorter-output / consumer-read bundle for sort_collector.
// master drives the sorter words and read requests; slave is the collector.
interface sort_collector_if #(
  parameter int WIDTH = 32
);

  logic signed [WIDTH-1:0] data_serial_i;
  logic                    data_valid_i;
  logic                    clear_i;
  logic                    rd_en_i;
  logic signed [WIDTH-1:0] data_o;
  logic                    rd_valid_o;
  logic                    frame_ready_o;
  logic                    sorted_ok_o;
  logic                    order_err_o;
  logic                    overflow_o;
  logic                    busy_o;

  modport master (
    output data_serial_i, data_valid_i, clear_i, rd_en_i,
    input  data_o, rd_valid_o, frame_ready_o, sorted_ok_o, order_err_o, overflow_o, busy_o
  );

  modport slave (
    input  data_serial_i, data_valid_i, clear_i, rd_en_i,
    output data_o, rd_valid_o, frame_ready_o, sorted_ok_o, order_err_o, overflow_o, busy_o
  );

endinterface

// File: rtl/sort_collector_comparator.sv
// Signed magnitude comparator, purely combinational (zero latency).
// No handshake; result follows its inputs.
module comparator #(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    lt,
  output logic                    gt
);

  assign lt = (a < b);
  assign gt = (a > b);

endmodule

// File: rtl/sort_collector.sv
// Captures one DEPTH-word frame from the sorter, order-checks it, replays it on request.
// Read latency 1 cycle; no backpressure upstream, words arriving during HOLD are dropped and flagged.
module sort_collector
  import sort_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = sort_pkg::DEPTH,
  parameter int ASCENDING = 1
) (
  input  logic            clk,
  input  logic            rst,
  sort_collector_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic signed [WIDTH-1:0] mem [DEPTH];
  state_t                  state;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic signed [WIDTH-1:0] prev;
  logic signed [WIDTH-1:0] data_q;
  logic                    rd_valid_q;
  logic                    frame_ready_q;
  logic                    sorted_ok_q;
  logic                    order_err_q;
  logic                    overflow_q;
  logic                    busy_q;

  logic lt;
  logic gt;
  logic viol;
  logic accept;

  comparator #(.WIDTH(WIDTH)) u_cmp (
    .a  (bus.data_serial_i),
    .b  (prev),
    .lt (lt),
    .gt (gt)
  );

  // The first word of a frame (taken in IDLE) has no predecessor to check against.
  assign viol   = (state == CAPTURE) && ((ASCENDING != 0) ? lt : gt);
  assign accept = bus.data_valid_i && !bus.clear_i && (state != HOLD);

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= bus.data_serial_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      prev          <= '0;
      data_q        <= '0;
      rd_valid_q    <= 1'b0;
      frame_ready_q <= 1'b0;
      sorted_ok_q   <= 1'b0;
      order_err_q   <= 1'b0;
      overflow_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      if (bus.clear_i) begin
        state         <= IDLE;
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        frame_ready_q <= 1'b0;
        sorted_ok_q   <= 1'b0;
        order_err_q   <= 1'b0;
        overflow_q    <= 1'b0;
        busy_q        <= 1'b0;
      end else begin
        case (state)
          IDLE, CAPTURE: begin
            if (bus.data_valid_i) begin
              prev <= bus.data_serial_i;
              if (viol) begin
                order_err_q <= 1'b1;
              end
              if (wr_ptr == LAST) begin
                state         <= HOLD;
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                frame_ready_q <= 1'b1;
                sorted_ok_q   <= !(order_err_q || viol);
                busy_q        <= 1'b0;
              end else begin
                state  <= CAPTURE;
                wr_ptr <= wr_ptr + PW'(1);
                busy_q <= 1'b1;
              end
            end
          end
          HOLD: begin
            if (bus.data_valid_i) begin
              overflow_q <= 1'b1;
            end
            if (bus.rd_en_i) begin
              data_q     <= mem[rd_ptr];
              rd_valid_q <= 1'b1;
              if (rd_ptr == LAST) begin
                state         <= IDLE;
                rd_ptr        <= '0;
                frame_ready_q <= 1'b0;
                sorted_ok_q   <= 1'b0;
                order_err_q   <= 1'b0;
              end else begin
                rd_ptr <= rd_ptr + PW'(1);
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.data_o        = data_q;
  assign bus.rd_valid_o    = rd_valid_q;
  assign bus.frame_ready_o = frame_ready_q;
  assign bus.sorted_ok_o   = sorted_ok_q;
  assign bus.order_err_o   = order_err_q;
  assign bus.overflow_o    = overflow_q;
  assign bus.busy_o        = busy_q;

endmodule
